ctrl_regfile: RTL
=================

Name: ctrl_regfile

Overview:
- Register-file target driven by the controller's result and error address outputs (ares/aerr) in the sample rate converter datapath.
- Holds one accumulator per polyphase result slot and one error/residue register per slot.
- Accumulates MAC products into the addressed slot and, on an output-sample event, saturates the finished sum into an output holding register.
- Presents the output to the downstream stage through a valid/ready handshake.

Parameters:
- WIDTH, 3: address width; depth = 2**WIDTH slots per file.
- DW, 16: sample/error data width, two's complement.
- GW, 4: accumulator guard bits; ACC_W = DW+GW.

Ports:
- clk  in  1  clock; all state updates on the rising edge; addresses change on the falling edge.
- rst  in  1  reset, synchronous, active-high.
- en_init  in  1  ring-buffer initialization cycle.
- en_load  in  1  accumulate/load cycle.
- out_smp  in  1  final accumulation for the current output sample.
- ares  in  WIDTH  result register address.
- aerr  in  WIDTH  error register address.
- mac_in  in  ACC_W  signed product/partial sum to accumulate.
- err_in  in  DW  error value to store.
- res_rdata  out  ACC_W  registered read of result[ares].
- err_rdata  out  DW  registered read of error[aerr].
- out_data  out  DW  saturated output sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accept.
- ovf  out  1  sticky: output sample dropped because the holding register was occupied.

Behaviour:
- Reset (rst=1 at posedge):
  - all result[] and error[] cleared;
  - res_rdata, err_rdata, out_data = 0;
  - out_valid = 0, ovf = 0.
  - rst overrides every other input, including a pending handshake; a held sample is discarded.
- Mode decode on {en_init,en_load}:
  - 10 (init): result[ares] <= 0; error[aerr] <= err_in.
  - 01 (load): result[ares] <= result[ares] + mac_in (ACC_W wrap-around, no saturation inside the accumulator); error[aerr] <= err_in.
  - 00 or 11: no write to either file. 11 is illegal and treated as idle.
- Output event: mode 01 with out_smp=1.
  - sum = result[ares] + mac_in, computed in ACC_W bits.
  - Saturate sum to DW: if sum > 2**(DW-1)-1 output 0x7FFF; if sum < -2**(DW-1) output 0x8000 (values for DW=16); otherwise sum[DW-1:0].
  - result[ares] <= 0, clearing the slot for the next sample instead of writing sum.
  - If the holding register is free (out_valid=0, or out_valid=1 with out_ready=1 in the same cycle): out_data <= saturated sum, out_valid <= 1 on the next edge. Latency is 1 clock from the event edge to out_valid.
  - Otherwise the new sample is dropped, out_data is unchanged, and ovf <= 1 (sticky until rst).
- Handshake:
  - A transfer occurs on a posedge with out_valid=1 and out_ready=1; out_valid then deasserts unless a new output event loads in the same cycle (back-to-back, no bubble).
  - out_data is stable while out_valid=1 and out_ready=0.
- Read ports:
  - res_rdata/err_rdata capture the pre-write contents of result[ares]/error[aerr] every posedge, regardless of mode (read-before-write).
  - Addresses ares and aerr may be equal or different; the two files are independent.
- Address wrap: addresses are used modulo 2**WIDTH; there is no range check.
- Reset mid-accumulation clears partial sums; the first load after reset accumulates from 0.

Test Plan:
1. Reset then init: rst=1 for 2 cycles, then en_init=1 with ares=0..7 and aerr=0..7, err_in=0x0011*addr → all result reads 0; err_rdata for aerr=5 returns 0x0055 on a later read.
2. Accumulate and output: en_load with ares=2, mac_in=100, 200, then out_smp=1 with mac_in=300 → out_valid=1 one clock later, out_data=600; result[2] reads 0 afterwards.
3. Saturation: accumulate 0x7000 three times at ares=1 with out_smp on the third → out_data=0x7FFF. Repeat with -0x7000 → out_data=0x8000.
4. Back-pressure and drop: out_ready=0, two output events 3 cycles apart (values 10, then 20) → out_data stays 10 and ovf=1. Raise out_ready → single transfer of 10, out_valid=0, ovf remains 1.
5. Back-to-back handshake: out_ready=1, output events on consecutive cycles (values 5, 6) → out_valid stays 1 for 2 cycles with out_data 5 then 6; ovf=0.
6. Illegal/idle and mid-op reset: {en_init,en_load}=11 with ares=3 → result[3] and error[3] unchanged. Partial sum 50 at ares=4, then rst=1 for one cycle, then load 7 with out_smp → out_data=7.

Source files
------------

// File: rtl/ctrl_regfile.sv
// Result/error register files for the sample rate converter controller.
// Accumulates MAC products per slot and saturates finished sums into a valid/ready output stage.
module ctrl_regfile #(
   parameter int WIDTH = 3,
   parameter int DW    = 16,
   parameter int GW    = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_init,
   input  logic                 en_load,
   input  logic                 out_smp,
   input  logic [WIDTH-1:0]     ares,
   input  logic [WIDTH-1:0]     aerr,
   input  logic [DW+GW-1:0]     mac_in,
   input  logic [DW-1:0]        err_in,
   output logic [DW+GW-1:0]     res_rdata,
   output logic [DW-1:0]        err_rdata,
   output logic [DW-1:0]        out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 ovf
);

   localparam int ACC_W = DW + GW;
   localparam int DEPTH = 2 ** WIDTH;

   typedef enum logic [1:0] {
      MODE_IDLE    = 2'b00,
      MODE_LOAD    = 2'b01,
      MODE_INIT    = 2'b10,
      MODE_ILLEGAL = 2'b11
   } mode_e;

   mode_e            mode;
   logic [ACC_W-1:0] res_mem [DEPTH];
   logic [DW-1:0]    err_mem [DEPTH];
   logic [ACC_W-1:0] sum;
   logic [DW-1:0]    sum_sat;
   logic             out_evt;
   logic             hold_free;

   assign mode      = mode_e'({en_init, en_load});
   assign sum       = res_mem[ares] + mac_in;
   assign out_evt   = (mode == MODE_LOAD) && out_smp;
   assign hold_free = !out_valid || out_ready;

   // In range exactly when every bit above the DW-1 sign bit matches it.
   // NOTE: sum_sat is assigned on every path so no latch is inferred.
   always_comb begin
      sum_sat = sum[DW-1:0];
      if (!(&sum[ACC_W-1:DW-1]) && (|sum[ACC_W-1:DW-1]))
         sum_sat = sum[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
   end

   // NOTE: state uses non-blocking assignments so every read sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: both files are cleared on reset because partial sums must restart from 0.
         for (int i = 0; i < DEPTH; i++) begin
            res_mem[i] <= '0;
            err_mem[i] <= '0;
         end
         res_rdata <= '0;
         err_rdata <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         res_rdata <= res_mem[ares];
         err_rdata <= err_mem[aerr];

         case (mode)
            MODE_INIT: begin
               res_mem[ares] <= '0;
               err_mem[aerr] <= err_in;
            end
            MODE_LOAD: begin
               res_mem[ares] <= out_smp ? '0 : sum;
               err_mem[aerr] <= err_in;
            end
            default: ;
         endcase

         if (out_evt && hold_free) begin
            out_data  <= sum_sat;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end

         if (out_evt && !hold_free)
            ovf <= 1'b1;
      end
   end

endmodule
